// File: rtl/mesi_isc_broad_n.sv
// mesi_isc_broad_n -- parametrised N-CPU coherence broadcast engine.
// Requests queue in a FIFO; each one is snooped to every other CPU, then granted to its originator.
module mesi_isc_broad_n #(
   parameter int N_CPU            = 4,
   parameter int CPU_ID_WIDTH     = 2,
   parameter int CBUS_CMD_WIDTH   = 3,
   parameter int ADDR_WIDTH       = 32,
   parameter int BROAD_TYPE_WIDTH = 2,
   parameter int BROAD_ID_WIDTH   = 5,
   parameter int FIFO_DEPTH       = 4,
   parameter int FIFO_DEPTH_LOG2  = 2,
   parameter int TIMEOUT_CYCLES   = 255
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_CPU-1:0]                  cbus_ack_array_i,
   input  logic                              broad_fifo_wr_i,
   input  logic [ADDR_WIDTH-1:0]             broad_addr_i,
   input  logic [BROAD_TYPE_WIDTH-1:0]       broad_type_i,
   input  logic [CPU_ID_WIDTH-1:0]           broad_cpu_id_i,
   input  logic [BROAD_ID_WIDTH-1:0]         broad_id_i,
   output logic [ADDR_WIDTH-1:0]             cbus_addr_o,
   output logic [N_CPU*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o,
   output logic [BROAD_ID_WIDTH-1:0]         active_id_o,
   output logic                              fifo_status_full_o,
   output logic [FIFO_DEPTH_LOG2:0]          fifo_count_o,
   output logic [2:0]                        err_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SNOOP  = 2'd1;
   localparam logic [1:0] ST_ENABLE = 2'd2;

   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = CBUS_CMD_WIDTH'(0);
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

   localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR = BROAD_TYPE_WIDTH'(1);
   localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD = BROAD_TYPE_WIDTH'(2);

   localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
   localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

   // Request storage; head is read combinationally so IDLE can act on it in the same cycle.
   logic [ADDR_WIDTH-1:0]       addr_mem [FIFO_DEPTH];
   logic [BROAD_TYPE_WIDTH-1:0] type_mem [FIFO_DEPTH];
   logic [CPU_ID_WIDTH-1:0]     cpu_mem  [FIFO_DEPTH];
   logic [BROAD_ID_WIDTH-1:0]   id_mem   [FIFO_DEPTH];

   logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic                        full_q, full_d;
   logic                        push, pop, overflow;

   logic [ADDR_WIDTH-1:0]       head_addr;
   logic [BROAD_TYPE_WIDTH-1:0] head_type;
   logic [CPU_ID_WIDTH-1:0]     head_cpu;
   logic [BROAD_ID_WIDTH-1:0]   head_id;

   logic [1:0]                  state_q, state_d;
   logic [N_CPU-1:0]            pending_q, pending_d;
   logic [CPU_ID_WIDTH-1:0]     orig_q, orig_d;
   logic                        is_wr_q, is_wr_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [BROAD_ID_WIDTH-1:0]   id_q, id_d;
   logic [WD_W-1:0]             wd_q, wd_d;
   logic [2:0]                  err_q, err_d;
   logic                        illegal_pop, start, ack_taken, timeout_hit;

   logic [N_CPU-1:0]                           others_mask;
   logic [N_CPU-1:0]                           orig_ack_vec;
   logic [N_CPU-1:0][CBUS_CMD_WIDTH-1:0]       cmd_q;
   logic [CBUS_CMD_WIDTH-1:0]                  cmd_d [N_CPU];

   assign push     = broad_fifo_wr_i & ~full_q;
   assign overflow = broad_fifo_wr_i & full_q;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= broad_addr_i;
         type_mem[wr_ptr_q] <= broad_type_i;
         cpu_mem[wr_ptr_q]  <= broad_cpu_id_i;
         id_mem[wr_ptr_q]   <= broad_id_i;
      end
   end

   assign head_addr = addr_mem[rd_ptr_q];
   assign head_type = type_mem[rd_ptr_q];
   assign head_cpu  = cpu_mem[rd_ptr_q];
   assign head_id   = id_mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(push);
      rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      full_d   = (count_d == CNT_W'(FIFO_DEPTH));
   end

   // Per-CPU decode: who gets snooped, originator ack, and next command from next-state registers.
   for (genvar gi = 0; gi < N_CPU; gi++) begin : g_cpu
      assign others_mask[gi]  = (head_cpu != CPU_ID_WIDTH'(gi));
      assign orig_ack_vec[gi] = cbus_ack_array_i[gi] & (orig_q == CPU_ID_WIDTH'(gi));
      assign cmd_d[gi] = (state_d == ST_SNOOP && pending_d[gi])              ?
                            (is_wr_d ? CMD_WR_SNOOP : CMD_RD_SNOOP)             :
                         (state_d == ST_ENABLE && orig_d == CPU_ID_WIDTH'(gi)) ?
                            (is_wr_d ? CMD_EN_WR : CMD_EN_RD)                   :
                            CMD_NOP;
   end

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      orig_d      = orig_q;
      is_wr_d     = is_wr_q;
      addr_d      = addr_q;
      id_d        = id_q;
      pop         = 1'b0;
      illegal_pop = 1'b0;
      start       = 1'b0;
      ack_taken   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               if (head_type == TYPE_WR || head_type == TYPE_RD) begin
                  start     = 1'b1;
                  pending_d = others_mask;
                  orig_d    = head_cpu;
                  is_wr_d   = (head_type == TYPE_WR);
                  addr_d    = head_addr;
                  id_d      = head_id;
                  state_d   = (others_mask != '0) ? ST_SNOOP : ST_ENABLE;
               end else begin
                  pop         = 1'b1;
                  illegal_pop = 1'b1;
               end
            end
         end
         ST_SNOOP: begin
            ack_taken = |(cbus_ack_array_i & pending_q);
            pending_d = pending_q & ~cbus_ack_array_i;
            if (pending_d == '0) begin
               state_d = ST_ENABLE;
            end
         end
         ST_ENABLE: begin
            ack_taken = |orig_ack_vec;
            if (ack_taken) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
               addr_d  = '0;
               id_d    = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Watchdog only observes; it flags a stalled broadcast but never aborts it.
   always_comb begin
      wd_d        = '0;
      timeout_hit = 1'b0;
      if (TIMEOUT_CYCLES != 0 && state_q != ST_IDLE) begin
         if (ack_taken) begin
            wd_d = '0;
         end else if (wd_q == WD_LIMIT) begin
            wd_d = wd_q;
         end else begin
            wd_d = wd_q + 1'b1;
         end
         timeout_hit = (wd_d == WD_LIMIT);
      end
   end

   assign err_d = err_q | {illegal_pop, timeout_hit, overflow};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         orig_q    <= '0;
         is_wr_q   <= 1'b0;
         addr_q    <= '0;
         id_q      <= '0;
         wd_q      <= '0;
         err_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         for (int i = 0; i < N_CPU; i++) begin
            cmd_q[i] <= CMD_NOP;
         end
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         orig_q    <= orig_d;
         is_wr_q   <= is_wr_d;
         addr_q    <= addr_d;
         id_q      <= id_d;
         wd_q      <= wd_d;
         err_q     <= err_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         for (int i = 0; i < N_CPU; i++) begin
            cmd_q[i] <= cmd_d[i];
         end
      end
   end

   assign cbus_addr_o        = addr_q;
   assign cbus_cmd_array_o   = cmd_q;
   assign active_id_o        = id_q;
   assign fifo_status_full_o = full_q;
   assign fifo_count_o       = count_q;
   assign err_o              = err_q;

endmodule

// File: doc/mesi_isc_broad_n.md
Name: mesi_isc_broad_n

Overview:
- Parametrised N-CPU coherence broadcast engine. Successor to the fixed 4-CPU broadcast stage of the MESI intersection controller.
- Buffers broadcast requests from the breq stage in a FIFO of configurable depth.
- For each request, snoops every non-originating CPU and collects their acks, then grants write or read enable to the originator.
- New versus the previous generation: N_CPU generalisation, occupancy output, no-ack watchdog, sticky error reporting.

Parameters:
- N_CPU, 4, number of CPU coherence ports (1..32).
- CPU_ID_WIDTH, 2, width of CPU index; must satisfy 2**CPU_ID_WIDTH >= N_CPU.
- CBUS_CMD_WIDTH, 3, coherence bus command width.
- ADDR_WIDTH, 32, address width.
- BROAD_TYPE_WIDTH, 2, broadcast type width.
- BROAD_ID_WIDTH, 5, broadcast id width.
- FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2).
- FIFO_DEPTH_LOG2, 2, log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 255, no-ack watchdog limit; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset.
- cbus_ack_array_i  in  N_CPU  per-CPU coherence ack; bit i = CPU i.
- broad_fifo_wr_i  in  1  push request.
- broad_addr_i  in  ADDR_WIDTH  request address.
- broad_type_i  in  BROAD_TYPE_WIDTH  1=WR, 2=RD, 0/3 illegal.
- broad_cpu_id_i  in  CPU_ID_WIDTH  originating CPU.
- broad_id_i  in  BROAD_ID_WIDTH  request tag.
- cbus_addr_o  out  ADDR_WIDTH  address of active broadcast; 0 when IDLE.
- cbus_cmd_array_o  out  N_CPU*CBUS_CMD_WIDTH  per-CPU command; CPU i occupies bits [i*W+W-1 : i*W].
- active_id_o  out  BROAD_ID_WIDTH  tag of active broadcast; 0 when IDLE.
- fifo_status_full_o  out  1  count == FIFO_DEPTH.
- fifo_count_o  out  FIFO_DEPTH_LOG2+1  occupancy.
- err_o  out  3  sticky flags: {illegal_type, timeout, overflow}.

Behaviour:
- Reset: rst sampled low at a clk edge clears everything. All outputs go to 0: cmds NOP, addr 0, count 0, full 0, err 0. FSM goes to IDLE. The FIFO is flushed, including mid-broadcast (no completion is issued).
- Command encoding: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
- All outputs are registered.
- FIFO write:
  - Push accepted iff broad_fifo_wr_i=1 and fifo_status_full_o=0 at the edge.
  - Push while full is dropped and sets err_o[0]. This applies even if a pop occurs in the same cycle.
  - Simultaneous push and pop with count < DEPTH leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SNOOP, ENABLE.
- IDLE:
  - If count > 0 and head type is legal, compute pending mask = all CPUs except the originator.
  - Mask nonzero: next state SNOOP. cmd_i = WR_SNOOP (type 1) or RD_SNOOP (type 2) for each pending i; originator cmd = NOP.
  - Mask zero (N_CPU=1): next state ENABLE directly.
  - cbus_addr_o and active_id_o load the head entry.
  - Head type illegal: pop head, set err_o[2], stay IDLE, issue no commands (one cycle per illegal entry).
- SNOOP:
  - cbus_ack_array_i[i]=1 while bit i is pending clears bit i; cmd_i becomes NOP the next cycle.
  - Acks on non-pending bits are ignored.
  - When the mask becomes zero (including acks in the current cycle), next state is ENABLE with originator cmd = EN_WR (type 1) or EN_RD (type 2). Minimum SNOOP duration is 1 cycle.
- ENABLE:
  - Originator cmd held until its ack is seen.
  - On ack: pop FIFO, next state IDLE, all cmds NOP, addr/id to 0.
  - Earliest next broadcast starts 1 cycle later (IDLE is always visited for at least one cycle).
- Latency: push at edge t into an empty, idle engine → count=1 at t+1 → SNOOP commands visible at t+2.
- Watchdog:
  - Counter clears on entry to SNOOP/ENABLE and on any accepted ack.
  - Increments each SNOOP/ENABLE cycle with no accepted ack.
  - On reaching TIMEOUT_CYCLES, sets err_o[1] and saturates. Operation is not aborted.
  - Inactive when TIMEOUT_CYCLES=0.
- Acks arriving in IDLE are ignored.

Test Plan:
- N_CPU=4: push WR addr 0x1000 cpu 2 id 5 → cycle t+2 cmd = {3:1, 2:0, 1:1, 0:1}, addr 0x1000, id 5. Ack CPUs 0,1,3 on separate cycles → each cmd drops to 0 the next cycle. After the last ack, cmd2=3; ack2 → all NOP, count 0.
- Push 4 RD requests back-to-back → full=1, count=4. 5th push dropped, err_o=3'b001. Requests are serviced in order, and tags appear on active_id_o in push order.
- Same-cycle acks from all three snooped CPUs → ENABLE next cycle (SNOOP lasts 1 cycle). Push+pop in the same cycle at count=2 → count stays 2.
- Push type 0 then WR → illegal entry popped with no cmds, err_o[2]=1. WR then proceeds normally.
- TIMEOUT_CYCLES=8, withhold acks → err_o[1]=1 after 8 SNOOP cycles, cmds still held. Late acks complete the broadcast.
- rst=0 mid-SNOOP with count=3 → next cycle all outputs 0, count 0. N_CPU=1 build: push WR cpu 0 → EN_WR at t+2, with no SNOOP state.
